// File: rtl/vend_ctrl_param_if.sv
// Vending controller bus: coin/cancel requests in, vend/change/reject status out.
// CW must match the credit width of the controller bound to it.
interface vend_ctrl_param_if #(
  parameter int CW = 8
);
  logic          coin_a;
  logic          coin_b;
  logic          cancel;
  logic          dispense;
  logic          change_pulse;
  logic          coin_reject;
  logic          busy;
  logic [CW-1:0] credit;

  modport master (
    output coin_a, coin_b, cancel,
    input  dispense, change_pulse, coin_reject, busy, credit
  );

  modport slave (
    input  coin_a, coin_b, cancel,
    output dispense, change_pulse, coin_reject, busy, credit
  );
endinterface

// File: rtl/vend_ctrl_param.sv
// Parameterised two-coin vending controller: accumulates credit, vends at PRICE,
// then pays change back one credit unit per cycle.
module vend_ctrl_param #(
  parameter int PRICE = 15,
  parameter int VAL_A = 5,
  parameter int VAL_B = 10,
  parameter int CW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  vend_ctrl_param_if.slave   bus
);
  localparam int MAX_VAL = (VAL_A > VAL_B) ? VAL_A : VAL_B;

  if ((PRICE < 1) || (VAL_A < 1) || (VAL_B < 1) || (PRICE + MAX_VAL - 1 >= 2**CW)) begin : g_bad_params
    $error("vend_ctrl_param: illegal PRICE/VAL_A/VAL_B/CW combination");
  end

  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
  localparam logic [CW-1:0] VAL_A_C = CW'(VAL_A);
  localparam logic [CW-1:0] VAL_B_C = CW'(VAL_B);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] credit_r;
  logic [CW-1:0] credit_s;
  logic          reject_r;
  logic          reject_s;
  logic          coin_any_s;
  logic [CW-1:0] add_s;
  logic [CW-1:0] sum_s;

  // Coin decode; the parameter check bounds sum below 2^CW so it cannot wrap.
  always_comb begin
    coin_any_s = bus.coin_a | bus.coin_b;
    add_s      = bus.coin_a ? VAL_A_C : VAL_B_C;
    sum_s      = credit_r + add_s;
  end

  // Next-state, next-credit and refusal decision.
  always_comb begin
    state_s  = state_r;
    credit_s = credit_r;
    reject_s = 1'b0;
    case (state_r)
      IDLE, ACCUM: begin
        if (bus.cancel) begin
          // A coin arriving with cancel is always refused; only ACCUM refunds.
          reject_s = coin_any_s;
          if (state_r == ACCUM) begin
            state_s = CHANGE;
          end else begin
            state_s = IDLE;
          end
        end else if (bus.coin_a && bus.coin_b) begin
          reject_s = 1'b1;
        end else if (coin_any_s) begin
          if (sum_s >= PRICE_C) begin
            state_s  = VEND;
            credit_s = sum_s - PRICE_C;
          end else begin
            state_s  = ACCUM;
            credit_s = sum_s;
          end
        end else begin
          state_s = state_r;
        end
      end
      VEND: begin
        reject_s = coin_any_s;
        if (credit_r == {CW{1'b0}}) begin
          state_s = IDLE;
        end else begin
          state_s = CHANGE;
        end
      end
      CHANGE: begin
        reject_s = coin_any_s;
        if (credit_r <= {{(CW-1){1'b0}}, 1'b1}) begin
          state_s  = IDLE;
          credit_s = {CW{1'b0}};
        end else begin
          credit_s = credit_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s  = IDLE;
        credit_s = {CW{1'b0}};
      end
    endcase
  end

  // State, credit and reject registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      credit_r <= {CW{1'b0}};
      reject_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      credit_r <= credit_s;
      reject_r <= reject_s;
    end
  end

  assign bus.dispense     = (state_r == VEND);
  assign bus.change_pulse = (state_r == CHANGE);
  assign bus.busy         = (state_r == VEND) | (state_r == CHANGE);
  assign bus.coin_reject  = reject_r;
  assign bus.credit       = credit_r;
endmodule

// File: tb/tb_vend_ctrl_param.sv
// Drives a default-parameter and a small-parameter controller with the same
// directed and random coin/cancel traffic and compares them to a credit-ledger model.
module tb_vend_ctrl_param;
  logic clk;
  logic rst;

  vend_ctrl_param_if #(.CW(8)) bus0 ();
  vend_ctrl_param_if #(.CW(4)) bus1 ();

  vend_ctrl_param #(.PRICE(15), .VAL_A(5), .VAL_B(10), .CW(8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  vend_ctrl_param #(.PRICE(7), .VAL_A(2), .VAL_B(3), .CW(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;

  // Ledger model: money held toward a purchase, a pending vend with its leftover,
  // and the number of refund units still owed.
  int price [2] = '{15, 7};
  int val_a [2] = '{5, 2};
  int val_b [2] = '{10, 3};
  int held  [2];
  int owed  [2];
  int left  [2];
  bit vend_due [2];
  bit refused  [2];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      held[k]     = 0;
      owed[k]     = 0;
      left[k]     = 0;
      vend_due[k] = 1'b0;
      refused[k]  = 1'b0;
    end
  endtask

  task automatic model_edge(input bit a, input bit b, input bit c);
    int sum;
    for (int k = 0; k < 2; k++) begin
      refused[k] = 1'b0;
      if (vend_due[k]) begin
        vend_due[k] = 1'b0;
        owed[k]     = left[k];
        refused[k]  = a | b;
      end else if (owed[k] > 0) begin
        owed[k]    = owed[k] - 1;
        refused[k] = a | b;
      end else if (c) begin
        refused[k] = a | b;
        owed[k]    = held[k];
        held[k]    = 0;
      end else if (a && b) begin
        refused[k] = 1'b1;
      end else if (a || b) begin
        sum = held[k] + (a ? val_a[k] : val_b[k]);
        if (sum >= price[k]) begin
          vend_due[k] = 1'b1;
          left[k]     = sum - price[k];
          held[k]     = 0;
        end else begin
          held[k] = sum;
        end
      end
    end
  endtask

  task automatic expect_outputs(input int k, output int disp, output int chg,
                                output int cred, output int rej);
    disp = vend_due[k] ? 1 : 0;
    chg  = (!vend_due[k] && owed[k] > 0) ? 1 : 0;
    cred = vend_due[k] ? left[k] : ((owed[k] > 0) ? owed[k] : held[k]);
    rej  = refused[k] ? 1 : 0;
  endtask

  task automatic check_outputs();
    int d, c, cr, r;
    expect_outputs(0, d, c, cr, r);
    check_val("d0.dispense", int'(bus0.dispense), d);
    check_val("d0.change_pulse", int'(bus0.change_pulse), c);
    check_val("d0.credit", int'(bus0.credit), cr);
    check_val("d0.busy", int'(bus0.busy), d | c);
    check_val("d0.coin_reject", int'(bus0.coin_reject), r);
    expect_outputs(1, d, c, cr, r);
    check_val("d1.dispense", int'(bus1.dispense), d);
    check_val("d1.change_pulse", int'(bus1.change_pulse), c);
    check_val("d1.credit", int'(bus1.credit), cr);
    check_val("d1.busy", int'(bus1.busy), d | c);
    check_val("d1.coin_reject", int'(bus1.coin_reject), r);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, ".d0.outs"}, int'({bus0.dispense, bus0.change_pulse, bus0.coin_reject, bus0.busy}), 0);
    check_val({tag, ".d0.credit"}, int'(bus0.credit), 0);
    check_val({tag, ".d1.outs"}, int'({bus1.dispense, bus1.change_pulse, bus1.coin_reject, bus1.busy}), 0);
    check_val({tag, ".d1.credit"}, int'(bus1.credit), 0);
  endtask

  task automatic cycle(input bit a, input bit b, input bit c);
    @(negedge clk);
    check_outputs();
    bus0.coin_a = a; bus0.coin_b = b; bus0.cancel = c;
    bus1.coin_a = a; bus1.coin_b = b; bus1.cancel = c;
    @(posedge clk);
    model_edge(a, b, c);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bus0.coin_a = 1'b0; bus0.coin_b = 1'b0; bus0.cancel = 1'b0;
    bus1.coin_a = 1'b0; bus1.coin_b = 1'b0; bus1.cancel = 1'b0;
    model_reset();
    rst = 1'b1;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Exact price with coin A, then overpay with coin B (change paid back).
    cycle(1'b1, 1'b0, 1'b0); cycle(1'b1, 1'b0, 1'b0); cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(4);
    cycle(1'b0, 1'b1, 1'b0); cycle(1'b0, 1'b1, 1'b0); cycle(1'b0, 1'b1, 1'b0);
    idle_cycles(8);

    // Coin then cancel: full refund, no vend.
    cycle(1'b1, 1'b0, 1'b0); cycle(1'b0, 1'b0, 1'b1);
    idle_cycles(7);

    // Double coin in IDLE refused; coin during CHANGE refused.
    cycle(1'b1, 1'b1, 1'b0); idle_cycles(1);
    cycle(1'b0, 1'b1, 1'b0); cycle(1'b0, 1'b1, 1'b0);
    idle_cycles(2);
    cycle(1'b0, 1'b1, 1'b0);
    idle_cycles(6);

    // Cancel together with a coin while accumulating.
    cycle(1'b1, 1'b0, 1'b0); cycle(1'b0, 1'b1, 1'b1);
    idle_cycles(7);

    // Asynchronous reset in the middle of change payout.
    cycle(1'b0, 1'b1, 1'b0); cycle(1'b0, 1'b1, 1'b0); cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    #1 rst = 1'b0;
    model_reset();
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(2);
    cycle(1'b0, 1'b0, 1'b1);
    idle_cycles(6);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
    end
    idle_cycles(20);

    @(negedge clk);
    check_outputs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
